// File: rtl/control_sequencer.sv
// Five-stage (IF/ID/EX/MEM/WB) control sequencer for the AVR-subset core; latches decoder fields in IF
// and drives register-file / memory strobes from state only. Optional MEM timeout: CONTROL_MEM_TIMEOUT_EN.

`ifndef OPCODE_COUNT
  `define OPCODE_COUNT 8
  `define TYPE_ADD  0
  `define TYPE_SUB  1
  `define TYPE_LDI  2
  `define TYPE_LDS  3
  `define TYPE_LD_Y 4
  `define TYPE_STS  5
  `define TYPE_MOV  6
  `define TYPE_NOP  7
`endif
`ifndef GROUP_COUNT
  `define GROUP_COUNT 2
  `define GROUP_ALU        0
  `define GROUP_ALU_TWO_OP 1
`endif
`ifndef STAGE_COUNT
  `define STAGE_COUNT 5
  `define STAGE_IF  0
  `define STAGE_ID  1
  `define STAGE_EX  2
  `define STAGE_MEM 3
  `define STAGE_WB  4
`endif
`ifndef SIGNAL_COUNT
  `define SIGNAL_COUNT 6
  `define CONTROL_RR_READ   0
  `define CONTROL_RD_READ   1
  `define CONTROL_RR_WRITE  2
  `define CONTROL_MEM_READ  3
  `define CONTROL_MEM_WRITE 4
  `define CONTROL_RD_WRITE  5
`endif

module control_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_valid,
  input  logic [`OPCODE_COUNT-1:0]   opcode_type,
  input  logic [`GROUP_COUNT-1:0]    opcode_group,
  input  logic                       stall,
  input  logic                       mem_ready,
  output logic [`STAGE_COUNT-1:0]    pipeline_stage,
  output logic [`SIGNAL_COUNT-1:0]   signals,
  output logic                       instr_done,
  output logic                       busy,
  output logic                       mem_error
);

  if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("control_sequencer: MEM_TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [`OPCODE_COUNT-1:0]   r_type;
  logic [`GROUP_COUNT-1:0]    r_group;
  logic                       w_is_mem;
  logic                       w_mem_done;
  logic                       w_abort;
  logic                       w_unused_type;

  assign w_is_mem = r_type[`TYPE_LDS] | r_type[`TYPE_LD_Y] | r_type[`TYPE_STS];
  // Opcode types that never steer a strobe on their own; ALU ops are recognised by group.
  assign w_unused_type = ^{r_type[`TYPE_ADD], r_type[`TYPE_SUB], r_type[`TYPE_NOP]};

`ifdef CONTROL_MEM_TIMEOUT_EN
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_abort;
  logic             r_mem_error;
  logic             w_timeout;

  // Ready in the final cycle wins over the timeout.
  assign w_timeout  = (r_state == S_MEM) && w_is_mem && !mem_ready &&
                      (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign w_mem_done = !w_is_mem || mem_ready || w_timeout;
  assign w_abort    = r_abort;
  assign mem_error  = r_mem_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt  <= '0;
      r_abort     <= 1'b0;
      r_mem_error <= 1'b0;
    end else begin
      if (r_state == S_EX) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_MEM && w_is_mem && !mem_ready &&
                   r_wait_cnt != CNT_W'(MEM_TIMEOUT)) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
      // WB always directly follows MEM, so the last MEM cycle decides abort.
      if (r_state == S_MEM) begin
        r_abort <= w_timeout;
      end
      if (w_timeout) begin
        r_mem_error <= 1'b1;
      end
    end
  end
`else
  assign w_mem_done = !w_is_mem || mem_ready;
  assign w_abort    = 1'b0;
  assign mem_error  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_type  <= '0;
      r_group <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IF) begin
        r_type  <= opcode_type;
        r_group <= opcode_group;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (instr_valid) w_next = S_IF;
      S_IF:    w_next = S_ID;
      S_ID:    if (!stall) w_next = S_EX;
      S_EX:    w_next = S_MEM;
      S_MEM:   if (w_mem_done) w_next = S_WB;
      S_WB:    w_next = instr_valid ? S_IF : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state and the opcode latch.
  always_comb begin
    pipeline_stage = '0;
    signals        = '0;
    instr_done     = 1'b0;
    busy           = (r_state != S_IDLE);
    case (r_state)
      S_IF:  pipeline_stage[`STAGE_IF] = 1'b1;
      S_ID: begin
        pipeline_stage[`STAGE_ID] = 1'b1;
        signals[`CONTROL_RR_READ] = r_group[`GROUP_ALU_TWO_OP] | r_type[`TYPE_STS] |
                                    r_type[`TYPE_MOV] | r_type[`TYPE_LD_Y];
        signals[`CONTROL_RD_READ] = r_group[`GROUP_ALU] | r_type[`TYPE_LD_Y];
      end
      S_EX:  pipeline_stage[`STAGE_EX] = 1'b1;
      S_MEM: begin
        pipeline_stage[`STAGE_MEM]  = 1'b1;
        signals[`CONTROL_MEM_READ]  = r_type[`TYPE_LDS] | r_type[`TYPE_LD_Y];
        signals[`CONTROL_MEM_WRITE] = r_type[`TYPE_STS];
      end
      S_WB: begin
        pipeline_stage[`STAGE_WB] = 1'b1;
        instr_done                = 1'b1;
        signals[`CONTROL_RD_WRITE] = (r_group[`GROUP_ALU] | r_type[`TYPE_LDI] | r_type[`TYPE_LDS] |
                                      r_type[`TYPE_LD_Y] | r_type[`TYPE_MOV]) & !w_abort;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: a driver issues instructions and queues per-instruction
// expectations; a monitor tallies strobes/stage cycles and compares on each instr_done.

`ifndef OPCODE_COUNT
  `define OPCODE_COUNT 8
  `define TYPE_ADD  0
  `define TYPE_SUB  1
  `define TYPE_LDI  2
  `define TYPE_LDS  3
  `define TYPE_LD_Y 4
  `define TYPE_STS  5
  `define TYPE_MOV  6
  `define TYPE_NOP  7
`endif
`ifndef GROUP_COUNT
  `define GROUP_COUNT 2
  `define GROUP_ALU        0
  `define GROUP_ALU_TWO_OP 1
`endif
`ifndef STAGE_COUNT
  `define STAGE_COUNT 5
  `define STAGE_IF  0
  `define STAGE_ID  1
  `define STAGE_EX  2
  `define STAGE_MEM 3
  `define STAGE_WB  4
`endif
`ifndef SIGNAL_COUNT
  `define SIGNAL_COUNT 6
  `define CONTROL_RR_READ   0
  `define CONTROL_RD_READ   1
  `define CONTROL_RR_WRITE  2
  `define CONTROL_MEM_READ  3
  `define CONTROL_MEM_WRITE 4
  `define CONTROL_RD_WRITE  5
`endif

module tb_control_sequencer;
  localparam int TO = 4;
`ifdef CONTROL_MEM_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                     instr_valid = 1'b0;
  logic [`OPCODE_COUNT-1:0] opcode_type = '0;
  logic [`GROUP_COUNT-1:0]  opcode_group = '0;
  logic                     stall = 1'b0;
  logic                     mem_ready = 1'b0;
  logic [`STAGE_COUNT-1:0]  pipeline_stage;
  logic [`SIGNAL_COUNT-1:0] signals;
  logic                     instr_done;
  logic                     busy;
  logic                     mem_error;

  control_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
    .opcode_type(opcode_type), .opcode_group(opcode_group),
    .stall(stall), .mem_ready(mem_ready),
    .pipeline_stage(pipeline_stage), .signals(signals),
    .instr_done(instr_done), .busy(busy), .mem_error(mem_error)
  );

  // Scoreboard
  typedef struct packed {
    logic [7:0] lat;
    logic [7:0] n_rr;
    logic [7:0] n_rd;
    logic [7:0] n_mr;
    logic [7:0] n_mw;
    logic [7:0] n_rdw;
    logic       merr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   model_merr = 1'b0;
  bit   prev_b2b = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: tallies per-instruction activity, compares at instr_done
  int c_lat, c_rr, c_rd, c_rrw, c_mr, c_mw, c_rdw, c_bad_stage;

  always @(negedge clk) begin
    if (!rst_n) begin
      c_lat = 0; c_rr = 0; c_rd = 0; c_rrw = 0; c_mr = 0; c_mw = 0; c_rdw = 0; c_bad_stage = 0;
    end else begin
      if (busy) c_lat++;
      c_rr  += int'(signals[`CONTROL_RR_READ]);
      c_rd  += int'(signals[`CONTROL_RD_READ]);
      c_rrw += int'(signals[`CONTROL_RR_WRITE]);
      c_mr  += int'(signals[`CONTROL_MEM_READ]);
      c_mw  += int'(signals[`CONTROL_MEM_WRITE]);
      c_rdw += int'(signals[`CONTROL_RD_WRITE]);
      if (busy ? !$onehot(pipeline_stage) : (pipeline_stage != '0)) c_bad_stage++;
      if (instr_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_instr_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("latency", c_lat, int'(e.lat));
          chk("rr_read_cycles", c_rr, int'(e.n_rr));
          chk("rd_read_cycles", c_rd, int'(e.n_rd));
          chk("rr_write_cycles", c_rrw, 0);
          chk("mem_read_cycles", c_mr, int'(e.n_mr));
          chk("mem_write_cycles", c_mw, int'(e.n_mw));
          chk("rd_write_cycles", c_rdw, int'(e.n_rdw));
          chk("mem_error", int'(mem_error), int'(e.merr));
          chk("done_in_wb", int'(pipeline_stage[`STAGE_WB]), 1);
          chk("stage_encoding", c_bad_stage, 0);
        end
        c_lat = 0; c_rr = 0; c_rd = 0; c_rrw = 0; c_mr = 0; c_mw = 0; c_rdw = 0; c_bad_stage = 0;
      end
    end
  end

  // Driver: reference model computes the expected outcome from the instruction's rules
  task automatic run_instr(input int tidx, input logic [1:0] grp, input int nstall,
                           input int d, input bit b2b);
    logic [`OPCODE_COUNT-1:0] typ;
    bit lds, ldy, sts, ldi, mov, mem_op, abort;
    int mem_cyc, id_cyc;
    exp_t e;
    typ = '0;
    typ[tidx] = 1'b1;
    lds = (tidx == `TYPE_LDS);
    ldy = (tidx == `TYPE_LD_Y);
    sts = (tidx == `TYPE_STS);
    ldi = (tidx == `TYPE_LDI);
    mov = (tidx == `TYPE_MOV);
    mem_op  = lds || ldy || sts;
    abort   = TIMEOUT_EN && mem_op && (d >= TO);
    mem_cyc = !mem_op ? 1 : (abort ? TO : d + 1);
    id_cyc  = nstall + 1;
    if (abort) model_merr = 1'b1;
    e.lat   = 8'(3 + id_cyc + mem_cyc);
    e.n_rr  = (grp[`GROUP_ALU_TWO_OP] || sts || mov || ldy) ? 8'(id_cyc) : 8'd0;
    e.n_rd  = (grp[`GROUP_ALU] || ldy) ? 8'(id_cyc) : 8'd0;
    e.n_mr  = (lds || ldy) ? 8'(mem_cyc) : 8'd0;
    e.n_mw  = sts ? 8'(mem_cyc) : 8'd0;
    e.n_rdw = ((grp[`GROUP_ALU] || ldi || lds || ldy || mov) && !abort) ? 8'd1 : 8'd0;
    e.merr  = model_merr;
    exp_q.push_back(e);

    @(posedge clk); #1;   // IF
    opcode_type = typ; opcode_group = grp; instr_valid = 1'b0;
    stall = 1'($urandom); mem_ready = 1'($urandom);
    @(posedge clk); #1;   // first ID cycle
    for (int i = 1; i <= id_cyc; i++) begin
      opcode_type = `OPCODE_COUNT'($urandom); opcode_group = `GROUP_COUNT'($urandom);
      stall = (i <= nstall); mem_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    stall = 1'($urandom); mem_ready = 1'($urandom);   // EX
    @(posedge clk); #1;
    for (int j = 1; j <= mem_cyc; j++) begin
      mem_ready = mem_op ? (j == d + 1) : 1'($urandom);
      stall = 1'($urandom);
      @(posedge clk); #1;
    end
    instr_valid = b2b; stall = 1'($urandom); mem_ready = 1'($urandom);   // WB
  endtask

  task automatic issue(input int tidx, input logic [1:0] grp, input int nstall,
                       input int d, input bit b2b);
    if (!prev_b2b) begin
      @(posedge clk); #1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      instr_valid = 1'b1;
    end
    run_instr(tidx, grp, nstall, d, b2b);
    prev_b2b = b2b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stage", int'(pipeline_stage), 0);
    chk("reset_signals", int'(signals), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(instr_done), 0);
    chk("reset_mem_error", int'(mem_error), 0);
    rst_n = 1'b1;

    issue(`TYPE_ADD, 2'b11, 0, 0, 1'b0);
    issue(`TYPE_LDS, 2'b00, 0, 3, 1'b0);
    issue(`TYPE_STS, 2'b00, 2, 0, 1'b1);
    issue(`TYPE_LD_Y, 2'b00, 0, TO - 1, 1'b0);
    issue(`TYPE_LD_Y, 2'b00, 0, TO, 1'b0);
    issue(`TYPE_ADD, 2'b11, 1, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      int t;
      t = $urandom_range(0, `OPCODE_COUNT - 1);
      issue(t, 2'($urandom), $urandom_range(0, 3), $urandom_range(0, TO + 1),
            (n != 39) && 1'($urandom));
    end

    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("queue_drained", exp_q.size(), 0);
    instr_valid = 1'b0;

    // Reset mid-MEM of an LDS that never completes
    @(posedge clk); #1;
    instr_valid = 1'b1;
    @(posedge clk); #1;   // IF
    instr_valid = 1'b0; opcode_type = '0; opcode_type[`TYPE_LDS] = 1'b1; opcode_group = '0;
    stall = 1'b0; mem_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #3;   // second MEM cycle
    chk("pre_reset_mem_read", int'(signals[`CONTROL_MEM_READ]), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_signals", int'(signals), 0);
    chk("async_reset_stage", int'(pipeline_stage), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_done", int'(instr_done), 0);
    chk("async_reset_mem_error", int'(mem_error), 0);
    model_merr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("idle_after_reset_busy", int'(busy), 0);
    chk("idle_after_reset_stage", int'(pipeline_stage), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
